prbs_ctrl: RTL and testbench

PRBS_CTRL -- requirements
Module: prbs_ctrl

---
 rtl/prbs_ctrl_if.sv | 33 +++
 rtl/prbs_ctrl.sv | 142 ++++++++++++++
 tb/tb_prbs_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_ctrl_if.sv
// prbs_ctrl_if: control/status bundle for the PRBS burst generator.
//   start, stop      burst request / abort (driven by master)
//   div              step period minus one, in clk cycles
//   seed             LFSR seed (zero selects the block's default seed)
//   burst_len        bits per burst, 0 = run until stop
//   prbs, prbs_valid emitted bit and its one-cycle qualifier
//   busy, done       activity level and completion pulse
//   lfsr_state       current LFSR contents
interface prbs_ctrl_if #(
   parameter int DIV_WIDTH = 4,
   parameter int LEN_WIDTH = 16
);
   logic                 start;
   logic                 stop;
   logic [DIV_WIDTH-1:0] div;
   logic [7:0]           seed;
   logic [LEN_WIDTH-1:0] burst_len;
   logic                 prbs;
   logic                 prbs_valid;
   logic                 busy;
   logic                 done;
   logic [7:0]           lfsr_state;

   modport master (
      output start, stop, div, seed, burst_len,
      input  prbs, prbs_valid, busy, done, lfsr_state
   );

   modport slave (
      input  start, stop, div, seed, burst_len,
      output prbs, prbs_valid, busy, done, lfsr_state
   );
endinterface

// File: rtl/prbs_ctrl.sv
// prbs_ctrl: burst PRBS generator built on an 8-bit Galois LFSR
// (x^8+x^4+x^3+x^2+1). One bit is emitted every div+1 clk cycles while
// running; a burst ends after burst_len bits or when stop is raised.
//   clk    single clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    prbs_ctrl_if.slave (start/stop/div/seed/burst_len in,
//          prbs/prbs_valid/busy/done/lfsr_state out)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; configuration captured on acceptance
// LOAD   | one cycle: seed the LFSR, clear tick and bit counters
// RUN    | tick counter runs 0..div; each tick emits one bit
// DONE   | one cycle after the last bit; done pulses as it leaves
module prbs_ctrl #(
   parameter int         DIV_WIDTH    = 4,
   parameter int         LEN_WIDTH    = 16,
   parameter logic [7:0] DEFAULT_SEED = 8'hFF
) (
   input logic        clk,
   input logic        rst_n,
   prbs_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t               state;
   logic [DIV_WIDTH-1:0] div_l;
   logic [DIV_WIDTH-1:0] tick_cnt;
   logic [LEN_WIDTH-1:0] len_l;
   logic [LEN_WIDTH-1:0] bit_cnt;
   logic [LEN_WIDTH-1:0] bit_cnt_inc;
   logic [7:0]           seed_l;
   logic [7:0]           lfsr;
   logic                 prbs_q;
   logic                 valid_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 tick;
   logic                 last_bit;

   function automatic logic [7:0] lfsr_next(input logic [7:0] o);
      logic [7:0] n;
      n[0] = o[7];
      n[1] = o[0];
      n[2] = o[1] ^ o[7];
      n[3] = o[2] ^ o[7];
      n[4] = o[3] ^ o[7];
      n[5] = o[4];
      n[6] = o[5];
      n[7] = o[6];
      return n;
   endfunction

   assign tick        = (tick_cnt == div_l);
   assign bit_cnt_inc = bit_cnt + LEN_WIDTH'(1);
   // burst_len of zero never terminates; the bit counter just wraps
   assign last_bit    = (len_l != '0) && (bit_cnt_inc == len_l);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         div_l    <= '0;
         len_l    <= '0;
         seed_l   <= '0;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         lfsr     <= DEFAULT_SEED;
         prbs_q   <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start && !bus.stop) begin
                  div_l  <= bus.div;
                  len_l  <= bus.burst_len;
                  seed_l <= bus.seed;
                  busy_q <= 1'b1;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (bus.stop) begin
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end else begin
                  // an all-zero seed would lock the LFSR at zero
                  lfsr     <= (seed_l == 8'h00) ? DEFAULT_SEED : seed_l;
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               // stop wins over a coincident tick: nothing is emitted
               if (bus.stop) begin
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end else if (tick) begin
                  tick_cnt <= '0;
                  prbs_q   <= lfsr[7];
                  lfsr     <= lfsr_next(lfsr);
                  bit_cnt  <= bit_cnt_inc;
                  valid_q  <= 1'b1;
                  if (last_bit) begin
                     state <= S_DONE;
                  end
               end else begin
                  tick_cnt <= tick_cnt + DIV_WIDTH'(1);
               end
            end
            S_DONE: begin
               // done is registered out of DONE so it trails the last
               // prbs_valid by exactly one cycle
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.prbs       = prbs_q;
   assign bus.prbs_valid = valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.lfsr_state = lfsr;

endmodule

// File: tb/tb_prbs_ctrl.sv
// tb_prbs_ctrl: directed and random stimulus for prbs_ctrl, checked every
// cycle against a burst-timing reference model, plus literal expectations.
module tb_prbs_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   prbs_ctrl_if #(.DIV_WIDTH(4), .LEN_WIDTH(16)) bus ();

   prbs_ctrl #(
      .DIV_WIDTH(4),
      .LEN_WIDTH(16),
      .DEFAULT_SEED(8'hFF)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int done_cnt    = 0;
   int last_done_cyc = -1;

   logic [7:0] obs_lfsr[$];
   logic       obs_prbs[$];
   int         obs_cyc[$];

   // reference model: a burst accepted at cycle c0 loads at c0+1, and
   // bit k (0-based) is emitted by a tick at c0+2+k*(div+1)+div
   bit         m_act   = 1'b0;
   int         m_c0    = 0;
   int         m_div   = 0;
   int         m_len   = 0;
   logic [7:0] m_seed  = 8'h00;
   logic [7:0] m_lfsr  = 8'hFF;
   logic       m_prbs  = 1'b0;
   logic       m_valid = 1'b0;
   logic       m_done  = 1'b0;
   logic       m_busy  = 1'b0;

   // polynomial form: multiply by x modulo x^8+x^4+x^3+x^2+1
   function automatic logic [7:0] gal(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
   endfunction

   function automatic logic [7:0] gal_n(input logic [7:0] v, input int n);
      logic [7:0] x = v;
      for (int i = 0; i < n; i++) x = gal(x);
      return x;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      int   c, r, rl;
      logic st, sp;
      c  = cyc;
      cyc++;
      st = bus.start;
      sp = bus.stop;
      if (!rst_n) begin
         m_act = 1'b0; m_lfsr = 8'hFF; m_prbs = 1'b0;
         m_valid = 1'b0; m_done = 1'b0; m_busy = 1'b0;
      end else begin
         m_valid = 1'b0;
         m_done  = 1'b0;
         if (m_act) begin
            r  = c - m_c0;
            rl = (m_len == 0) ? 32'h7FFF_FFF0 : 1 + m_len * (m_div + 1);
            if (r == rl + 1) begin
               m_done = 1'b1;
               m_act  = 1'b0;
            end else if (sp) begin
               m_act = 1'b0;
            end else if (r == 1) begin
               m_lfsr = (m_seed == 8'h00) ? 8'hFF : m_seed;
            end else if (r >= 2 && ((r - 2) % (m_div + 1)) == m_div) begin
               m_prbs  = m_lfsr[7];
               m_lfsr  = gal(m_lfsr);
               m_valid = 1'b1;
            end
         end else if (st && !sp) begin
            m_act  = 1'b1;
            m_c0   = c;
            m_div  = int'(bus.div);
            m_len  = int'(bus.burst_len);
            m_seed = bus.seed;
         end
         m_busy = m_act;
      end
      #1;
      vectors++;
      if (bus.prbs !== m_prbs || bus.prbs_valid !== m_valid ||
          bus.busy !== m_busy || bus.done !== m_done ||
          bus.lfsr_state !== m_lfsr) begin
         miscompares++;
         $display("FAIL cycle %0d: got prbs=%b vld=%b busy=%b done=%b lfsr=%h expected prbs=%b vld=%b busy=%b done=%b lfsr=%h",
                  c, bus.prbs, bus.prbs_valid, bus.busy, bus.done, bus.lfsr_state,
                  m_prbs, m_valid, m_busy, m_done, m_lfsr);
      end
      if (bus.prbs_valid === 1'b1) begin
         obs_lfsr.push_back(bus.lfsr_state);
         obs_prbs.push_back(bus.prbs);
         obs_cyc.push_back(c);
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         last_done_cyc = c;
      end
   end

   task automatic clear_obs();
      obs_lfsr.delete();
      obs_prbs.delete();
      obs_cyc.delete();
   endtask

   task automatic pulse_start(input int d, input logic [7:0] s, input int l);
      @(negedge clk);
      bus.div       = 4'(d);
      bus.seed      = s;
      bus.burst_len = 16'(l);
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int n = 0;
      while ((bus.busy || bus.done) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) chk({nm, "_timeout"}, n, 0);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] lit_a[4];
      logic [7:0] exp_l;
      int n, d0;
      lit_a[0] = 8'hE3; lit_a[1] = 8'hDB; lit_a[2] = 8'hAB; lit_a[3] = 8'h4B;

      bus.start = 1'b0; bus.stop = 1'b0; bus.div = '0;
      bus.seed = 8'h00; bus.burst_len = '0;
      repeat (3) @(negedge clk);
      chk("rst_lfsr", int'(bus.lfsr_state), 8'hFF);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_prbs", int'(bus.prbs), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // seed FF, div 0, four bits
      clear_obs();
      pulse_start(0, 8'hFF, 4);
      wait_idle("a", 100);
      chk("a_count", obs_lfsr.size(), 4);
      for (int i = 0; i < 4 && i < obs_lfsr.size(); i++) begin
         chk($sformatf("a_lfsr%0d", i), int'(obs_lfsr[i]), int'(lit_a[i]));
         chk($sformatf("a_prbs%0d", i), int'(obs_prbs[i]), 1);
      end
      if (obs_cyc.size() == 4) begin
         chk("a_consecutive", obs_cyc[3] - obs_cyc[0], 3);
         chk("a_done_gap", last_done_cyc - obs_cyc[3], 1);
      end
      chk("a_busy_after", int'(bus.busy), 0);

      // zero seed falls back to the default seed
      clear_obs();
      pulse_start(0, 8'h00, 1);
      @(negedge clk);
      chk("b_loaded", int'(bus.lfsr_state), 8'hFF);
      wait_idle("b", 100);
      chk("b_count", obs_lfsr.size(), 1);
      if (obs_lfsr.size() == 1) begin
         chk("b_lfsr", int'(obs_lfsr[0]), 8'hE3);
         chk("b_prbs", int'(obs_prbs[0]), 1);
      end

      // div 3: pulses four clocks apart
      clear_obs();
      pulse_start(3, 8'h5A, 3);
      wait_idle("c", 100);
      chk("c_count", obs_cyc.size(), 3);
      if (obs_cyc.size() == 3) begin
         chk("c_gap1", obs_cyc[1] - obs_cyc[0], 4);
         chk("c_gap2", obs_cyc[2] - obs_cyc[1], 4);
         chk("c_done_gap", last_done_cyc - obs_cyc[2], 1);
      end

      // continuous burst, stop raised in a tick cycle after ten bits
      clear_obs();
      d0 = done_cnt;
      pulse_start(0, 8'h37, 0);
      n = 0;
      while (obs_lfsr.size() < 10 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("d_timeout", n, 0);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      chk("d_busy", int'(bus.busy), 0);
      repeat (3) @(negedge clk);
      chk("d_count", obs_lfsr.size(), 10);
      chk("d_frozen", int'(bus.lfsr_state), int'(gal_n(8'h37, 10)));
      chk("d_no_done", done_cnt - d0, 0);

      // start with stop in IDLE is refused; start while running is ignored
      @(negedge clk);
      bus.start = 1'b1; bus.stop = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.stop = 1'b0;
      chk("e_refused", int'(bus.busy), 0);
      clear_obs();
      pulse_start(1, 8'h11, 5);
      repeat (3) @(negedge clk);
      bus.seed = 8'hA5; bus.div = 4'd0; bus.burst_len = 16'd1; bus.start = 1'b1;
      repeat (2) @(negedge clk);
      bus.start = 1'b0;
      wait_idle("e", 100);
      chk("e_count", obs_lfsr.size(), 5);
      if (obs_lfsr.size() == 5) chk("e_first", int'(obs_lfsr[0]), int'(gal(8'h11)));

      // asynchronous reset mid-run
      d0 = done_cnt;
      pulse_start(0, 8'h80, 0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("f_lfsr", int'(bus.lfsr_state), 8'hFF);
      chk("f_busy", int'(bus.busy), 0);
      chk("f_valid", int'(bus.prbs_valid), 0);
      chk("f_prbs", int'(bus.prbs), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("f_no_done", done_cnt - d0, 0);
      chk("f_idle", int'(bus.busy), 0);
      clear_obs();
      pulse_start(0, 8'hFF, 2);
      wait_idle("f", 100);
      chk("f_count", obs_lfsr.size(), 2);
      if (obs_lfsr.size() == 2) begin
         chk("f_lfsr0", int'(obs_lfsr[0]), 8'hE3);
         chk("f_lfsr1", int'(obs_lfsr[1]), 8'hDB);
      end

      // random traffic, checked cycle by cycle against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         bus.start     = ($urandom_range(0, 7) == 0);
         bus.stop      = ($urandom_range(0, 24) == 0);
         bus.div       = 4'($urandom_range(0, 3));
         bus.seed      = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
         bus.burst_len = 16'($urandom_range(0, 6));
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      wait_idle("rnd", 100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
